isqrt_seq: RTL

- Iterative integer square-root responder: accepts one radicand, returns floor(sqrt(x)) after a fixed number of cycles.
- Serves as the far end of the x_vld/x -> y_vld/y request/response interface that the formula FSMs drive.
- Non-pipelined: one operation in flight; exposes x_rdy so an initiator can tell when a new request is taken.
- Minimal area: one bit-pair iteration per clock, restoring digit-by-digit algorithm.

---
 rtl/isqrt_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/isqrt_seq.sv
// ============================================================================
//  Module   : isqrt_seq
//  Purpose  : Iterative restoring integer square root, floor(sqrt(x)), one
//             bit-pair per clock. Optional sticky overrun flag when the
//             macro ISQRT_SEQ_OVERRUN_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module isqrt_seq #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_vld,
  input  logic [N-1:0]     x,
  output logic             x_rdy,
  output logic             y_vld,
`ifdef ISQRT_SEQ_OVERRUN_EN
  output logic             overrun,
`endif
  output logic [N/2-1:0]   y
);

  localparam int H  = N / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    rad_q,   rad_d;
  logic [H+1:0]    rem_q,   rem_d;
  logic [H-1:0]    root_q,  root_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [H-1:0]    y_q,     y_d;

  logic [H+1:0]    w_rem_sh;
  logic [H+1:0]    w_trial;

  assign x_rdy = (state_q != CALC);
  assign y_vld = (state_q == DONE);
  assign y     = y_q;

  // Shifted partial remainder and trial divisor for this bit-pair
  assign w_rem_sh = (rem_q << 2) | {{H{1'b0}}, rad_q[N-1:N-2]};
  assign w_trial  = {root_q, 2'b01};

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    y_d     = y_q;

    case (state_q)
      IDLE, DONE: begin
        if (x_vld) begin
          rad_d   = x;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(H - 1);
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rad_d = rad_q << 2;
        if (w_rem_sh >= w_trial) begin
          rem_d  = w_rem_sh - w_trial;
          root_d = {root_q[H-2:0], 1'b1};
        end else begin
          rem_d  = w_rem_sh;
          root_d = {root_q[H-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          y_d     = root_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

`ifdef ISQRT_SEQ_OVERRUN_EN
  logic overrun_q;

  // Sticky record of any request presented while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (x_vld && !x_rdy) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule

`default_nettype wire
